// File: rtl/yuvrgb_pkg.sv
// Shared constants and types for the BT.601 YUV-to-RGB converter.
package yuvrgb_pkg;

  localparam int SUM_W   = 20;
  localparam int LATENCY = 4;

  localparam int COEF_Y  = 298;
  localparam int COEF_RV = 409;
  localparam int COEF_GU = 100;
  localparam int COEF_GV = 208;
  localparam int COEF_BU = 516;

  localparam int OFF_Y = 16;
  localparam int OFF_C = 128;
  localparam int RND   = 128;

  typedef logic signed [8:0]       diff_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } ctl_t;

endpackage

// File: rtl/yuvrgb_if.sv
// Pixel bus into and out of the converter, plus the clip-counter controls.
interface yuvrgb_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [7:0]       i_y;
  logic [7:0]       i_u;
  logic [7:0]       i_v;
  logic             i_sof;
  logic             i_eol;
  logic             clr_cnt;
  logic             o_valid;
  logic [7:0]       o_r;
  logic [7:0]       o_g;
  logic [7:0]       o_b;
  logic             o_sof;
  logic             o_eol;
  logic [CNT_W-1:0] o_clip_cnt;

  modport slave (
    input  i_valid, i_y, i_u, i_v, i_sof, i_eol, clr_cnt,
    output o_valid, o_r, o_g, o_b, o_sof, o_eol, o_clip_cnt
  );

  modport master (
    output i_valid, i_y, i_u, i_v, i_sof, i_eol, clr_cnt,
    input  o_valid, o_r, o_g, o_b, o_sof, o_eol, o_clip_cnt
  );
endinterface

// File: rtl/yuvrgb_clip8.sv
// Floor-shifts a rounded sum by 8 and clamps it to 0..255, flagging any clamp.
module yuvrgb_clip8
  import yuvrgb_pkg::*;
(
  input  sum_t       i_sum,
  output logic [7:0] o_pix,
  output logic       o_clip
);

  sum_t w_shr;

  assign w_shr = i_sum >>> 8;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_pix  = w_shr[7:0];
    o_clip = 1'b0;
    if (w_shr < sum_t'(0)) begin
      o_pix  = 8'h00;
      o_clip = 1'b1;
    end else if (w_shr > sum_t'(255)) begin
      o_pix  = 8'hFF;
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/yuvrgb.sv
// Four-stage BT.601 YUV-to-RGB pipeline with a saturating per-pixel clip counter.
module yuvrgb
  import yuvrgb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  yuvrgb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctl_t r_ctl1, r_ctl2, r_ctl3;

  diff_t r_c, r_d, r_e;
  sum_t  r_p_yc, r_p_rv, r_p_gu, r_p_gv, r_p_bu;
  sum_t  r_sum_r, r_sum_g, r_sum_b;

  logic [7:0] w_r, w_g, w_b;
  logic       w_clip_r, w_clip_g, w_clip_b;
  logic       w_clip;

  logic             r_o_valid, r_o_sof, r_o_eol;
  logic [7:0]       r_o_r, r_o_g, r_o_b;
  logic [CNT_W-1:0] r_clip_cnt;

  // Control travels beside the data; markers are qualified by valid on entry.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl1 <= '0;
      r_ctl2 <= '0;
      r_ctl3 <= '0;
    end else begin
      r_ctl1 <= '{valid: bus.i_valid,
                  sof:   bus.i_valid & bus.i_sof,
                  eol:   bus.i_valid & bus.i_eol};
      r_ctl2 <= r_ctl1;
      r_ctl3 <= r_ctl2;
    end
  end

  // NOTE: datapath registers have no reset; the stage valid bits decide whether they matter.
  always_ff @(posedge clk) begin
    r_c <= diff_t'({1'b0, bus.i_y}) - diff_t'(OFF_Y);
    r_d <= diff_t'({1'b0, bus.i_u}) - diff_t'(OFF_C);
    r_e <= diff_t'({1'b0, bus.i_v}) - diff_t'(OFF_C);

    r_p_yc <= sum_t'(r_c) * sum_t'(COEF_Y);
    r_p_rv <= sum_t'(r_e) * sum_t'(COEF_RV);
    r_p_gu <= sum_t'(r_d) * sum_t'(COEF_GU);
    r_p_gv <= sum_t'(r_e) * sum_t'(COEF_GV);
    r_p_bu <= sum_t'(r_d) * sum_t'(COEF_BU);

    r_sum_r <= r_p_yc + r_p_rv + sum_t'(RND);
    r_sum_g <= r_p_yc - r_p_gu - r_p_gv + sum_t'(RND);
    r_sum_b <= r_p_yc + r_p_bu + sum_t'(RND);
  end

  yuvrgb_clip8 u_clip_r (.i_sum(r_sum_r), .o_pix(w_r), .o_clip(w_clip_r));
  yuvrgb_clip8 u_clip_g (.i_sum(r_sum_g), .o_pix(w_g), .o_clip(w_clip_g));
  yuvrgb_clip8 u_clip_b (.i_sum(r_sum_b), .o_pix(w_b), .o_clip(w_clip_b));

  assign w_clip = w_clip_r | w_clip_g | w_clip_b;

  // Colour outputs hold through bubbles; the counter counts pixels, not channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid  <= 1'b0;
      r_o_sof    <= 1'b0;
      r_o_eol    <= 1'b0;
      r_o_r      <= 8'h00;
      r_o_g      <= 8'h00;
      r_o_b      <= 8'h00;
      r_clip_cnt <= '0;
    end else begin
      r_o_valid <= r_ctl3.valid;
      r_o_sof   <= r_ctl3.valid & r_ctl3.sof;
      r_o_eol   <= r_ctl3.valid & r_ctl3.eol;
      if (r_ctl3.valid) begin
        r_o_r <= w_r;
        r_o_g <= w_g;
        r_o_b <= w_b;
      end
      if (bus.clr_cnt) begin
        r_clip_cnt <= '0;
      end else if (r_ctl3.valid && w_clip && (r_clip_cnt != CNT_MAX)) begin
        r_clip_cnt <= r_clip_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid    = r_o_valid;
  assign bus.o_sof      = r_o_sof;
  assign bus.o_eol      = r_o_eol;
  assign bus.o_r        = r_o_r;
  assign bus.o_g        = r_o_g;
  assign bus.o_b        = r_o_b;
  assign bus.o_clip_cnt = r_clip_cnt;

endmodule

// File: tb/tb_yuvrgb.sv
// Self-checking bench for yuvrgb: fixed vectors, directed corner sequences and
// randomized traffic against an arithmetic reference model with a 4-edge delay line.
module tb_yuvrgb;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  yuvrgb_if #(.CNT_W(CNT_W)) bus ();
  yuvrgb #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit valid;
    bit sof;
    bit eol;
    int y;
    int u;
    int v;
  } px_t;

  typedef struct {
    int y, u, v;
    int r, g, b;
    bit clip;
  } vec_t;

  px_t hist[4];
  bit  m_valid, m_sof, m_eol;
  int  m_r, m_g, m_b, m_cnt;
  int  cyc = 0;
  int  out_cycs[$];
  int  sof_cycs[$];
  int  eol_cycs[$];

  task automatic check(string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic void convert(input int y, input int u, input int v,
                                  output int r, output int g, output int b,
                                  output bit clipped);
    int c, d, e, rr, gg, bb;
    c  = y - 16;
    d  = u - 128;
    e  = v - 128;
    rr = (298 * c + 409 * e + 128) >>> 8;
    gg = (298 * c - 100 * d - 208 * e + 128) >>> 8;
    bb = (298 * c + 516 * d + 128) >>> 8;
    r  = clamp(rr);
    g  = clamp(gg);
    b  = clamp(bb);
    clipped = (r != rr) || (g != gg) || (b != bb);
  endfunction

  function automatic px_t pix(int y, int u, int v, bit sof = 1'b0, bit eol = 1'b0);
    px_t p;
    p.valid = 1'b1; p.sof = sof; p.eol = eol;
    p.y = y; p.u = u; p.v = v;
    return p;
  endfunction

  function automatic px_t idle(bit sof = 1'b0, bit eol = 1'b0);
    px_t p;
    p.valid = 1'b0; p.sof = sof; p.eol = eol;
    p.y = 0; p.u = 0; p.v = 0;
    return p;
  endfunction

  // One clock: apply inputs, advance the reference model, compare every output.
  task automatic drive(input px_t p, input bit clr = 1'b0, input bit rst_in = 1'b0);
    px_t head;
    bit  clipped;
    bus.i_valid = p.valid;
    bus.i_sof   = p.sof;
    bus.i_eol   = p.eol;
    bus.i_y     = 8'(p.y);
    bus.i_u     = 8'(p.u);
    bus.i_v     = 8'(p.v);
    bus.clr_cnt = clr;
    rst         = rst_in;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_in) begin
      for (int i = 0; i < 4; i++) hist[i] = idle();
      m_valid = 1'b0; m_sof = 1'b0; m_eol = 1'b0;
      m_r = 0; m_g = 0; m_b = 0; m_cnt = 0;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = p;
      hist[0].sof = p.valid & p.sof;
      hist[0].eol = p.valid & p.eol;
      head    = hist[3];
      m_valid = head.valid;
      m_sof   = head.sof;
      m_eol   = head.eol;
      clipped = 1'b0;
      if (head.valid) convert(head.y, head.u, head.v, m_r, m_g, m_b, clipped);
      if (clr) m_cnt = 0;
      else if (head.valid && clipped && m_cnt < CNT_MAX) m_cnt++;
    end
    check("o_valid", bus.o_valid, m_valid);
    check("o_sof", bus.o_sof, m_sof);
    check("o_eol", bus.o_eol, m_eol);
    check("o_r", bus.o_r, m_r);
    check("o_g", bus.o_g, m_g);
    check("o_b", bus.o_b, m_b);
    check("o_clip_cnt", bus.o_clip_cnt, m_cnt);
    if (bus.o_valid === 1'b1) out_cycs.push_back(cyc);
    if (bus.o_sof === 1'b1) sof_cycs.push_back(cyc);
    if (bus.o_eol === 1'b1) eol_cycs.push_back(cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   in_cycs[$];
    int   cnt_before, exp_cnt;
    px_t  p;

    vecs[0] = '{16, 128, 128, 0, 0, 0, 1'b0};
    vecs[1] = '{235, 128, 128, 255, 255, 255, 1'b0};
    vecs[2] = '{255, 128, 128, 255, 255, 255, 1'b1};
    vecs[3] = '{0, 128, 128, 0, 0, 0, 1'b1};
    vecs[4] = '{81, 90, 240, 255, 0, 0, 1'b1};
    vecs[5] = '{128, 128, 128, 130, 130, 130, 1'b0};
    vecs[6] = '{16, 128, 255, 203, 0, 0, 1'b1};

    for (int i = 0; i < 4; i++) hist[i] = idle();
    repeat (3) drive(idle(), 1'b0, 1'b1);
    check("reset_valid", bus.o_valid, 1'b0);
    check("reset_rgb", {bus.o_r, bus.o_g, bus.o_b}, 24'h0);
    check("reset_cnt", bus.o_clip_cnt, 0);
    drive(idle());

    // Single isolated pixels against hand-computed results.
    foreach (vecs[k]) begin
      cnt_before = int'(bus.o_clip_cnt);
      drive(pix(vecs[k].y, vecs[k].u, vecs[k].v));
      repeat (2) drive(idle());
      check("tbl_early_valid", bus.o_valid, 1'b0);
      drive(idle());
      check("tbl_valid", bus.o_valid, 1'b1);
      check("tbl_r", bus.o_r, vecs[k].r);
      check("tbl_g", bus.o_g, vecs[k].g);
      check("tbl_b", bus.o_b, vecs[k].b);
      exp_cnt = cnt_before + (vecs[k].clip ? 1 : 0);
      if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
      check("tbl_cnt", bus.o_clip_cnt, exp_cnt);
      drive(idle());
      check("tbl_valid_drop", bus.o_valid, 1'b0);
    end

    // 8-pixel line with a 2-cycle bubble; markers on bubble cycles must be ignored.
    out_cycs.delete(); sof_cycs.delete(); eol_cycs.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 5) begin
        drive(idle(1'b1, 1'b1));
      end else begin
        in_cycs.push_back(cyc + 1);
        drive(pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  i == 0, i == 9));
      end
    end
    repeat (5) drive(idle());
    check("stream_count", out_cycs.size(), 8);
    if (out_cycs.size() == 8) begin
      foreach (in_cycs[k]) check("stream_latency", out_cycs[k] - in_cycs[k], 3);
    end
    check("stream_sof_count", sof_cycs.size(), 1);
    check("stream_eol_count", eol_cycs.size(), 1);
    if (sof_cycs.size() == 1) check("stream_sof_pos", sof_cycs[0], in_cycs[0] + 3);
    if (eol_cycs.size() == 1) check("stream_eol_pos", eol_cycs[0], in_cycs[7] + 3);

    // Counter saturation, then clear colliding with a clipping output.
    drive(idle(), 1'b1);
    check("sat_cleared", bus.o_clip_cnt, 0);
    repeat (CNT_MAX + 2) drive(pix(255, 128, 128));
    repeat (4) drive(idle());
    check("sat_hold", bus.o_clip_cnt, CNT_MAX);
    drive(pix(0, 128, 128));
    repeat (2) drive(idle());
    drive(idle(), 1'b1);
    check("clr_prio_valid", bus.o_valid, 1'b1);
    check("clr_prio_cnt", bus.o_clip_cnt, 0);

    // Reset with pixels in flight: nothing stale may emerge afterwards.
    repeat (3) drive(pix(255, 128, 128));
    repeat (2) begin
      drive(idle(), 1'b0, 1'b1);
      check("rst_flight_valid", bus.o_valid, 1'b0);
      check("rst_flight_rgb", {bus.o_r, bus.o_g, bus.o_b}, 24'h0);
      check("rst_flight_cnt", bus.o_clip_cnt, 0);
    end
    out_cycs.delete();
    repeat (5) drive(idle());
    check("rst_no_stale", out_cycs.size(), 0);
    check("rst_rgb_after", {bus.o_r, bus.o_g, bus.o_b}, 24'h0);
    drive(pix(128, 128, 128));
    repeat (2) drive(idle());
    check("rst_new_early", bus.o_valid, 1'b0);
    drive(idle());
    check("rst_new_valid", bus.o_valid, 1'b1);
    check("rst_new_r", bus.o_r, 130);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 7)
        p = pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      else
        p = idle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      drive(p, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    repeat (5) drive(idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuvrgb.md
Name: yuvrgb

Overview:
- Pipelined BT.601 YUV-to-RGB converter, the inverse of the team's RGB-to-YUV skin-detect path.
- Sits on the display/readback side: takes 8-bit Y/U/V pixels with valid and frame markers, and produces 8-bit clamped R/G/B.
- Fixed latency; no backpressure.
- Counts pixels whose result saturated, for calibration checks.

Parameters:
- CNT_W, 16, width of the saturating clip-event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  input pixel qualifier.
- i_y  input  8  luma, unsigned.
- i_u  input  8  Cb, unsigned, offset 128.
- i_v  input  8  Cr, unsigned, offset 128.
- i_sof  input  1  start-of-frame marker; meaningful only with i_valid.
- i_eol  input  1  end-of-line marker; meaningful only with i_valid.
- clr_cnt  input  1  synchronous clear of o_clip_cnt.
- o_valid  output  1  output pixel qualifier.
- o_r  output  8  red, clamped 0..255.
- o_g  output  8  green, clamped 0..255.
- o_b  output  8  blue, clamped 0..255.
- o_sof  output  1  delayed i_sof, gated by valid.
- o_eol  output  1  delayed i_eol, gated by valid.
- o_clip_cnt  output  CNT_W  count of output pixels with at least one clamped channel.

Behaviour:
- Arithmetic, integer BT.601:
  - C = Y-16, D = U-128, E = V-128, each signed 9-bit.
  - R = clip((298C + 409E + 128) >>> 8)
  - G = clip((298C - 100D - 208E + 128) >>> 8)
  - B = clip((298C + 516D + 128) >>> 8)
  - `>>>` is an arithmetic shift (floor).
  - Products and sums are signed 20-bit minimum; B can reach 136882, so 18 bits is insufficient.
  - clip: <0 gives 0; >255 gives 255; otherwise the low 8 bits.
- Pipeline: 4 register stages, each carrying valid/sof/eol alongside the data.
  - S1: register C, D, E.
  - S2: register the five products.
  - S3: register the three sums including +128.
  - S4: shift, clip, register the outputs and the clip flag.
- Timing: a pixel sampled at edge t appears on the outputs after edge t+3 with o_valid=1.
- Back-to-back pixels are supported; throughput is 1 pixel/clk. Bubbles propagate unchanged.
- When the S4 input is invalid:
  - o_valid=0, o_sof=0, o_eol=0.
  - o_r/o_g/o_b hold their last values.
- Clip flag: 1 if any of R, G, B was clamped, low or high. The counter is per pixel, not per channel.
- o_clip_cnt:
  - Increments at the edge where o_valid is registered 1 with clip flag 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets it to 0 and has priority over a same-cycle increment.
- Reset:
  - o_valid, o_sof, o_eol = 0; o_r/o_g/o_b = 0; o_clip_cnt = 0.
  - All stage valid bits cleared.
  - In-flight pixels are dropped; no output until 4 edges after the first valid input following reset release.
- i_sof/i_eol are ignored when i_valid=0.

Decomposition:
- Package yuvrgb_pkg: coefficients 298, 409, 100, 208, 516; offsets 16, 128; rounding constant 128; internal width SUM_W=20; LATENCY=4.
- One sub-module, yuvrgb_clip8: signed SUM_W in, shift by 8, 8-bit clamped out plus a clipped flag. Instantiated 3 times in S4.

Test Plan:
- Y=16,U=128,V=128 single pixel at edge t -> after edge t+3: o_valid=1, RGB=(0,0,0), o_clip_cnt=0; o_valid=0 on the next cycle.
- Y=235,U=128,V=128 -> (255,255,255), no clip. Y=255 -> (255,255,255) with o_clip_cnt +1. Y=0 -> (0,0,0) with o_clip_cnt +1 (sum -4640 >>> 8 = -19).
- Y=81,U=90,V=240 -> (255,0,0); B clamped low, G exactly 0; o_clip_cnt increments by exactly 1.
- Stream of 8 contiguous pixels with i_sof on the first and i_eol on the last, including a 2-cycle bubble -> identical gaps on o_valid; o_sof/o_eol align with the first/last outputs; latency is 4 throughout.
- Preload o_clip_cnt to 2^CNT_W-2 (CNT_W=4 build), drive 3 clipping pixels -> counter stops at 15. Assert clr_cnt on the same cycle as a clipping output -> counter reads 0.
- Assert rst with 3 pixels in flight -> o_valid stays 0, all outputs 0 during and after reset, no stale pixels emerge; a new pixel after release appears 4 edges later.
